// File: rtl/sensor_pkg.sv
// Shared constants and types for the sensor command link (transmit and receive paths).
package sensor_pkg;

  localparam logic [7:0]  CMD_HDR0   = 8'hFF;
  localparam logic [7:0]  CMD_HDR1   = 8'hAA;
  localparam logic [7:0]  UNLOCK_REG = 8'h69;
  localparam logic [15:0] UNLOCK_VAL = 16'hB588;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } sensor_cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_e;
  typedef enum logic [1:0] {FR_IDLE, FR_SEND, FR_GAP} frame_state_e;

  // Byte 0 sits in the low bits so bytes go out in increasing index order.
  function automatic logic [39:0] build_frame(input sensor_cmd_t cmd);
    return {cmd.data[15:8], cmd.data[7:0], cmd.addr, CMD_HDR1, CMD_HDR0};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [39:0] frame, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = frame[7:0];
      3'd1:    b = frame[15:8];
      3'd2:    b = frame[23:16];
      3'd3:    b = frame[31:24];
      default: b = frame[39:32];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer for one byte, LSB first; a new byte can be taken in the last stop-bit cycle.
module uart_tx_byte
  import sensor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       txd
);

  localparam int BIT_W = $clog2(CLKS_PER_BIT);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state, state_next;
  logic [BIT_W-1:0] bit_timer, bit_timer_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic             txd_next;
  logic             bit_end;

  assign bit_end    = (bit_timer == BIT_LAST);
  assign byte_ready = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_timer <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      txd       <= 1'b1;
    end else begin
      state     <= state_next;
      bit_timer <= bit_timer_next;
      bit_idx   <= bit_idx_next;
      shift     <= shift_next;
      txd       <= txd_next;
    end
  end

  // The shift register moves right so the next data bit is always shift[1].
  always_comb begin
    state_next     = state;
    bit_timer_next = ((state == ST_IDLE) || bit_end) ? '0 : bit_timer + 1'b1;
    bit_idx_next   = bit_idx;
    shift_next     = shift;
    txd_next       = txd;
    case (state)
      ST_IDLE: begin
        if (byte_valid) begin
          state_next = ST_START;
          shift_next = byte_data;
          txd_next   = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next   = ST_DATA;
          bit_idx_next = '0;
          txd_next     = shift[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_next = ST_STOP;
            txd_next   = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = {1'b0, shift[7:1]};
            txd_next     = shift[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (byte_valid) begin
            state_next = ST_START;
            shift_next = byte_data;
            txd_next   = 1'b0;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/sensor_cmd_tx.sv
// Frames register-write commands as FF AA addr data_lo data_hi over UART with a trailing idle gap.
// Define SENSOR_CMD_UNLOCK_EN to send the unlock frame (FF AA 69 88 B5) plus gap ahead of every command.
module sensor_cmd_tx
  import sensor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int GAP_BITS     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        txd,
  output logic        busy,
  output logic        done
);

  localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  frame_state_e     state, state_next;
  logic             armed;
  logic [2:0]       byte_idx, byte_idx_next;
  logic [GAP_W-1:0] gap_timer, gap_timer_next;
  logic [39:0]      frame_q, frame_next;
  logic             byte_valid, byte_ready;
  logic [7:0]       byte_data;
  logic             frame_end, gap_end, last_frame, accept, launch;

`ifdef SENSOR_CMD_UNLOCK_EN
  logic        unlock_phase, unlock_phase_next;
  sensor_cmd_t cmd_q, cmd_next;
  assign last_frame = !unlock_phase;
`else
  assign last_frame = 1'b1;
`endif

  // The ready/done cycle is the final idle cycle, so an accept there starts the next start bit on time.
  assign frame_end  = (state == FR_SEND) && (byte_idx == 3'd4) && byte_ready;
  assign gap_end    = (GAP_CYCLES == 0) ? frame_end : ((state == FR_GAP) && (gap_timer == GAP_LAST));
  assign done       = gap_end && last_frame;
  assign cmd_ready  = armed && ((state == FR_IDLE) || done);
  assign busy       = (state != FR_IDLE) && !done;
  assign accept     = cmd_valid && cmd_ready;
  assign launch     = accept || (gap_end && !last_frame);
  assign byte_valid = launch || ((state == FR_SEND) && (byte_idx != 3'd4) && byte_ready);
  assign byte_data  = launch ? CMD_HDR0 : frame_byte(frame_q, byte_idx + 3'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FR_IDLE;
      armed     <= 1'b0;
      byte_idx  <= '0;
      gap_timer <= '0;
      frame_q   <= '0;
`ifdef SENSOR_CMD_UNLOCK_EN
      unlock_phase <= 1'b0;
      cmd_q        <= '0;
`endif
    end else begin
      state     <= state_next;
      armed     <= 1'b1;
      byte_idx  <= byte_idx_next;
      gap_timer <= gap_timer_next;
      frame_q   <= frame_next;
`ifdef SENSOR_CMD_UNLOCK_EN
      unlock_phase <= unlock_phase_next;
      cmd_q        <= cmd_next;
`endif
    end
  end

  always_comb begin
    state_next     = state;
    byte_idx_next  = byte_idx;
    gap_timer_next = gap_timer;
    frame_next     = frame_q;
`ifdef SENSOR_CMD_UNLOCK_EN
    unlock_phase_next = unlock_phase;
    cmd_next          = cmd_q;
`endif
    if (launch) begin
      state_next    = FR_SEND;
      byte_idx_next = '0;
`ifdef SENSOR_CMD_UNLOCK_EN
      if (accept) begin
        frame_next        = build_frame({UNLOCK_REG, UNLOCK_VAL});
        cmd_next          = {cmd_addr, cmd_data};
        unlock_phase_next = 1'b1;
      end else begin
        frame_next        = build_frame(cmd_q);
        unlock_phase_next = 1'b0;
      end
`else
      frame_next = build_frame({cmd_addr, cmd_data});
`endif
    end else begin
      case (state)
        FR_SEND: begin
          if (byte_ready) begin
            if (byte_idx != 3'd4) begin
              byte_idx_next = byte_idx + 3'd1;
            end else begin
              state_next     = (GAP_CYCLES == 0) ? FR_IDLE : FR_GAP;
              gap_timer_next = '0;
            end
          end
        end
        FR_GAP: begin
          if (gap_end) state_next = FR_IDLE;
          else         gap_timer_next = gap_timer + 1'b1;
        end
        default: ;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .txd        (txd)
  );

endmodule

// File: tb/tb_sensor_cmd_tx.sv
// Bench for sensor_cmd_tx: cycle-level line model, UART byte monitor and directed scenarios.
module tb_sensor_cmd_tx;

  localparam int CPB = 4;
  localparam int GAP = 2;
`ifdef SENSOR_CMD_UNLOCK_EN
  localparam int DONE_AT = 416;
`else
  localparam int DONE_AT = 208;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_ready, txd, busy, done;

  int tests_run = 0;
  int tests_failed = 0;

  sensor_cmd_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .txd       (txd),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Line model: every accepted command becomes a list of per-cycle expected outputs.
  typedef struct packed {
    logic txd;
    logic ready;
    logic done;
    logic busy;
    logic chk_busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  bit   model_live = 0;
  int   cycle = 0;
  int   accept_cycles[$];

  function automatic void push_bits(input logic t, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{t, 1'b0, 1'b0, 1'b1, 1'b1});
  endfunction

  function automatic void push_byte(input logic [7:0] b);
    push_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) push_bits(b[i], CPB);
    push_bits(1'b1, CPB);
  endfunction

  function automatic void push_frame(input logic [7:0] b0, b1, b2, b3, b4, input bit last);
    push_byte(b0); push_byte(b1); push_byte(b2); push_byte(b3); push_byte(b4);
    push_bits(1'b1, GAP * CPB - 1);
    if (last) exp_q.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    else      push_bits(1'b1, 1);
  endfunction

  always @(posedge clk) begin
    cycle++;
    if (!rst_n) begin
      exp_q.delete();
      cur = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    end else begin
      if (cur.ready && cmd_valid) begin
        accept_cycles.push_back(cycle);
`ifdef SENSOR_CMD_UNLOCK_EN
        push_frame(8'hFF, 8'hAA, 8'h69, 8'h88, 8'hB5, 1'b0);
`endif
        push_frame(8'hFF, 8'hAA, cmd_addr, cmd_data[7:0], cmd_data[15:8], 1'b1);
      end
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else                  cur = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    end
    model_live = 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      check_output("model_txd", txd, cur.txd);
      check_output("model_ready", cmd_ready, cur.ready);
      check_output("model_done", done, cur.done);
      if (cur.chk_busy) check_output("model_busy", busy, cur.busy);
    end
  end

  // UART receiver: samples each bit mid-way and drops a byte cut short by reset.
  logic [7:0] rx_q[$];
  logic [7:0] exp_bytes[$];

  initial begin : monitor
    logic [7:0] b;
    logic       stopb;
    bit         aborted;
    b = '0;
    stopb = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        aborted = 0;
        repeat (CPB / 2) begin @(negedge clk); if (!rst_n) aborted = 1; end
        for (int j = 0; j < 9; j++) begin
          repeat (CPB) begin @(negedge clk); if (!rst_n) aborted = 1; end
          if (j < 8) b[j] = txd;
          else       stopb = txd;
        end
        if (!aborted) begin
          check_output("stop_bit", stopb, 1'b1);
          rx_q.push_back(b);
        end
      end
    end
  end

  task automatic push5(input logic [7:0] b0, b1, b2, b3, b4);
    exp_bytes.push_back(b0); exp_bytes.push_back(b1); exp_bytes.push_back(b2);
    exp_bytes.push_back(b3); exp_bytes.push_back(b4);
  endtask

  task automatic push_unlock();
`ifdef SENSOR_CMD_UNLOCK_EN
    push5(8'hFF, 8'hAA, 8'h69, 8'h88, 8'hB5);
`endif
  endtask

  task automatic check_rx(input string name);
    int n;
    check_output({name, "_count"}, rx_q.size(), exp_bytes.size());
    n = (rx_q.size() < exp_bytes.size()) ? rx_q.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) check_output({name, "_byte"}, rx_q[i], exp_bytes[i]);
    rx_q.delete();
    exp_bytes.delete();
  endtask

  task automatic wait_ready(input int max_cyc);
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (cur.ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check_output("ready_timeout", 32'd0, 32'd1);
  endtask

  // Called at a falling edge; returns just after the accepting rising edge.
  task automatic apply_stimulus(input logic [7:0] a, input logic [15:0] d);
    wait_ready(2000);
    #1;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = 8'($urandom);
    cmd_data  = 16'($urandom);
  endtask

  logic [7:0]  b2b_addr[3] = '{8'h11, 8'h22, 8'h33};
  logic [15:0] b2b_data[3] = '{16'hA1B2, 16'hC3D4, 16'hE5F6};

  initial begin : stimulus
    int done_cnt;
    int done_at;
    int n0;
    bit ok;
    bit found;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("rst_txd", txd, 1'b1);
      check_output("rst_busy", busy, 1'b0);
      check_output("rst_done", done, 1'b0);
      check_output("rst_ready", cmd_ready, 1'b0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("release_ready", cmd_ready, 1'b1);
    check_output("release_busy", busy, 1'b0);

    rx_q.delete();
    apply_stimulus(8'h03, 16'h0006);
    for (int k = 1; k <= DONE_AT; k++) begin
      @(negedge clk);
      check_output("frame_done", done, 32'(k == DONE_AT));
      check_output("frame_ready", cmd_ready, 32'(k == DONE_AT));
    end
    repeat (2) @(negedge clk);
    push_unlock();
    push5(8'hFF, 8'hAA, 8'h03, 8'h06, 8'h00);
    check_rx("single");

    accept_cycles.delete();
    for (int i = 0; i < 3; i++) begin
      n0 = accept_cycles.size();
      #1;
      cmd_addr  = b2b_addr[i];
      cmd_data  = b2b_data[i];
      cmd_valid = 1'b1;
      push_unlock();
      push5(8'hFF, 8'hAA, b2b_addr[i], b2b_data[i][7:0], b2b_data[i][15:8]);
      ok = 0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        if (accept_cycles.size() > n0) begin ok = 1; break; end
      end
      if (!ok) check_output("b2b_accept_timeout", 32'd0, 32'd1);
    end
    #1 cmd_valid = 1'b0;
    wait_ready(1000);
    repeat (2) @(negedge clk);
    check_rx("b2b");
    check_output("b2b_accepts", accept_cycles.size(), 32'd3);
    if (accept_cycles.size() == 3) begin
      check_output("b2b_spacing1", accept_cycles[1] - accept_cycles[0], DONE_AT);
      check_output("b2b_spacing2", accept_cycles[2] - accept_cycles[1], DONE_AT);
    end

    apply_stimulus(8'h12, 16'h3456);
    repeat (20) @(negedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = 8'h55;
    cmd_data  = 16'h5555;
    @(negedge clk);
    #1 cmd_valid = 1'b0;
    wait_ready(1000);
    repeat (2) @(negedge clk);
    found = 0;
    foreach (rx_q[i]) if (rx_q[i] == 8'h55) found = 1;
    check_output("busy_ignored_55", 32'(found), 32'd0);
    push_unlock();
    push5(8'hFF, 8'hAA, 8'h12, 8'h56, 8'h34);
    check_rx("busy_ignore");

    apply_stimulus(8'h03, 16'h0006);
    repeat (90) @(negedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("midrst_txd", txd, 1'b1);
      check_output("midrst_ready", cmd_ready, 1'b0);
      check_output("midrst_busy", busy, 1'b0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("midrst_release_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check_output("midrst_quiet_txd", txd, 1'b1);
    end
    exp_bytes.push_back(8'hFF);
    exp_bytes.push_back(8'hAA);
    check_rx("midrst");

    apply_stimulus(8'h00, 16'h0000);
    done_cnt = 0;
    done_at  = 0;
    for (int k = 1; k <= DONE_AT + 16; k++) begin
      @(negedge clk);
      if (done) begin done_cnt++; done_at = k; end
    end
    check_output("zero_done_count", done_cnt, 32'd1);
    check_output("zero_done_at", done_at, DONE_AT);
    push_unlock();
    push5(8'hFF, 8'hAA, 8'h00, 8'h00, 8'h00);
    check_rx("zero");

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sensor_cmd_tx.md
Name: sensor_cmd_tx

Overview:
UART transmitter that sends configuration command frames to the wireless sensor module over `wireless_rx`. It is the transmit-side counterpart of the sensor receive path. It runs in the `clk_uart` domain and takes one register-write command at a time through a valid/ready handshake. Each command is serialized as one 5-byte frame, 8N1, LSB first: `0xFF 0xAA addr data[7:0] data[15:8]`.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range ≥ 2.
- GAP_BITS, 2, idle (mark) bit-times inserted after each frame before the block accepts the next command; legal range ≥ 0.

Ports:
- clk  in  1  UART-domain clock (`clk_uart`).
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_addr  in  8  sensor register address.
- cmd_data  in  16  register value.
- txd  out  1  serial line to `wireless_rx`; idle high.
- busy  out  1  frame or gap in progress.
- done  out  1  one-cycle pulse when a frame's gap completes.

Behaviour:
- Reset (rst_n=0 at a rising edge) sets the following, all applied at that edge:
  - outputs: txd=1, busy=0, done=0, cmd_ready=0;
  - internal: bit counters and byte index cleared;
  - the frame in progress is discarded, and no partial stop bit is emitted.
- The cycle after reset release: cmd_ready=1.
- Handshake:
  - Accept occurs on a rising edge with cmd_valid & cmd_ready.
  - addr/data are latched into a 40-bit frame register at that edge.
  - cmd_ready drops the same edge and stays 0 until the gap ends.
  - cmd_valid while cmd_ready=0 is ignored; nothing is queued.
  - cmd_addr/cmd_data are don't-care except at accept.
- FSM states: IDLE, START, DATA, STOP, GAP.
  - IDLE: txd=1, cmd_ready=1, busy=0. On accept → START; byte index=0, bit timer=0.
  - START: txd=0 for CLKS_PER_BIT cycles → DATA; bit index=0.
  - DATA: txd=current byte[bit index], each bit held CLKS_PER_BIT cycles. After bit 7 → STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. Then:
    - if byte index<4: increment it → START;
    - else → GAP, or straight to the IDLE transition below if GAP_BITS=0.
  - GAP: txd=1 for GAP_BITS*CLKS_PER_BIT cycles. Then → IDLE, with done=1 for exactly that one transition cycle.
- Latency:
  - The start bit of byte 0 appears on txd the first cycle after the accept edge.
  - Frame length = 50*CLKS_PER_BIT cycles.
  - Accept-to-next-ready = (50+GAP_BITS)*CLKS_PER_BIT cycles.
  - done asserts in the same cycle cmd_ready returns to 1.
- busy=1 in every state except IDLE.
- txd is registered: no combinational path from inputs, glitch-free.
- Bit timer width is $clog2(CLKS_PER_BIT); gap timer width is $clog2(GAP_BITS*CLKS_PER_BIT+1). No wrap-around within a bit.
- Simultaneous events:
  - An accept during the done cycle is legal: back-to-back frames, next start bit the following cycle.
  - Reset wins over everything.

Optional Feature:
- SENSOR_CMD_UNLOCK_EN defined:
  - Every accepted command is preceded by the unlock frame `0xFF 0xAA 0x69 0x88 0xB5` (50 bit-times).
  - Then GAP_BITS idle, then the command frame, then GAP_BITS idle.
  - done pulses only once, after the command frame's gap.
  - Accept-to-ready = (100+2*GAP_BITS)*CLKS_PER_BIT.
- Undefined: single frame only, exactly as above.

Decomposition:
- `runner_pkg`-style shared package `sensor_pkg` holds:
  - header constants `CMD_HDR0=8'hFF`, `CMD_HDR1=8'hAA`;
  - the unlock register/value constants;
  - `typedef struct packed {logic [7:0] addr; logic [15:0] data;} sensor_cmd_t`.
  - The sensor receiver reuses these constants.
- Sub-module `uart_tx_byte` owns START/DATA/STOP for one byte (byte-valid/ready in, txd out). `sensor_cmd_tx` owns frame sequencing, byte index, GAP, and the handshake.

Test Plan:
- Reset hold 5 cycles, release → txd=1 throughout; cmd_ready=1 on the first cycle after release; busy=0; done=0.
- CLKS_PER_BIT=4, GAP_BITS=2; send addr=0x03, data=0x0006.
  - Sampled bytes must be FF AA 03 06 00, each with start=0 and stop=1, LSB first.
  - done at cycle 208 after accept; cmd_ready=0 over cycles 1..207.
- Hold cmd_valid high continuously with 3 distinct commands → exactly 3 frames, back-to-back with the 8-cycle gap between them; no command lost or duplicated.
- Pulse cmd_valid during busy with addr=0x55 → ignored; no 0x55 byte ever appears on txd.
- Assert rst_n=0 mid-DATA of byte 2 → txd=1 at the next edge; no further transitions; cmd_ready=1 one cycle after release.
- With SENSOR_CMD_UNLOCK_EN, send addr=0x00, data=0x0000:
  - line carries FF AA 69 88 B5, an 8-cycle gap, then FF AA 00 00 00;
  - single done pulse at cycle 416.
